// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame width, clock constants.
// Imported by uart_rx and the other UART blocks.
package uart_pkg;

    localparam int CLK_FREQ_HZ          = 100_000_000;
    localparam int BAUD_RATE            = 115_200;
    localparam int DEFAULT_CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
    localparam int DATA_BITS            = 8;
    localparam int BIT_IDX_W            = $clog2(DATA_BITS);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
        S_WAIT_HIGH = 3'd4
    } state_t;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for an asynchronous single-bit input.
// Ports: clk, reset (sync, active-high), d (async in), q (synchronized out).
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART 8N1 receiver, LSB first, mid-bit sampling via a bit-period counter.
// Ports: clk, reset (sync, active-high), rx (async serial, idle high),
//        data (last good byte), rx_valid (1-cycle pulse),
//        frame_err (1-cycle pulse), rx_busy (frame in progress).
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int CNT_W        = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 rx_busy
);

    localparam logic [CNT_W-1:0] HALF_TC = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_TC  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_IDX_W-1:0] LAST_BIT = BIT_IDX_W'(DATA_BITS - 1);

    logic rx_s;

    state_t                 state, state_n;
    logic [CNT_W-1:0]       cnt, cnt_n;
    logic [BIT_IDX_W-1:0]   bit_idx, bit_idx_n;
    logic [DATA_BITS-1:0]   shift_reg, shift_n;
    logic [DATA_BITS-1:0]   data_n;
    logic                   valid_n, err_n;

    sync_2ff #(
        .RESET_VAL(1'b1)
    ) u_sync (
        .clk  (clk),
        .reset(reset),
        .d    (rx),
        .q    (rx_s)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            data      <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            bit_idx   <= bit_idx_n;
            shift_reg <= shift_n;
            data      <= data_n;
            rx_valid  <= valid_n;
            frame_err <= err_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt + CNT_W'(1);
        bit_idx_n = bit_idx;
        shift_n   = shift_reg;
        data_n    = data;
        valid_n   = 1'b0;
        err_n     = 1'b0;
        unique case (state)
            S_IDLE: begin
                cnt_n = '0;
                if (!rx_s) state_n = S_START;
            end
            S_START: begin
                // Re-check the line at mid start bit to reject glitches.
                if (cnt == HALF_TC) begin
                    cnt_n     = '0;
                    bit_idx_n = '0;
                    state_n   = rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt == BIT_TC) begin
                    cnt_n            = '0;
                    shift_n[bit_idx] = rx_s;
                    bit_idx_n        = bit_idx + BIT_IDX_W'(1);
                    if (bit_idx == LAST_BIT) state_n = S_STOP;
                end
            end
            S_STOP: begin
                // Leaving mid stop bit lets a back-to-back start edge be seen.
                if (cnt == BIT_TC) begin
                    cnt_n = '0;
                    if (rx_s) begin
                        data_n  = shift_reg;
                        valid_n = 1'b1;
                        state_n = S_IDLE;
                    end else begin
                        err_n   = 1'b1;
                        state_n = S_WAIT_HIGH;
                    end
                end
            end
            S_WAIT_HIGH: begin
                // A held-low line (break) must not decode as 0x00 frames.
                cnt_n = '0;
                if (rx_s) state_n = S_IDLE;
            end
            default: begin
                cnt_n   = '0;
                state_n = S_IDLE;
            end
        endcase
    end

    assign rx_busy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed cases plus random frames
// checked every cycle against a frame-level expectation queue.
module tb_uart_rx;

    localparam int C  = 16;
    localparam int H  = C / 2;
    localparam int CL = 868;

    typedef struct {
        bit         err;
        logic [7:0] b;
        int         due;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       rx;
    logic [7:0] data;
    logic       rx_valid;
    logic       frame_err;
    logic       rx_busy;

    logic       rx_l;
    logic [7:0] data_l;
    logic       rx_valid_l;
    logic       frame_err_l;
    logic       rx_busy_l;

    int         checks;
    int         failures;
    int         cyc;
    bit         chk_en;
    exp_t       exp_q[$];
    logic [7:0] model_data;
    logic [7:0] pulse_log[$];
    int         pulse_cnt;
    int         err_cnt;
    int         last_cyc;
    int         l_cnt;
    int         l_err;
    int         l_cyc;

    uart_rx #(
        .CLKS_PER_BIT(C),
        .CNT_W       (16)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rx       (rx),
        .data     (data),
        .rx_valid (rx_valid),
        .frame_err(frame_err),
        .rx_busy  (rx_busy)
    );

    uart_rx #(
        .CLKS_PER_BIT(CL),
        .CNT_W       (16)
    ) dut_l (
        .clk      (clk),
        .reset    (reset),
        .rx       (rx_l),
        .data     (data_l),
        .rx_valid (rx_valid_l),
        .frame_err(frame_err_l),
        .rx_busy  (rx_busy_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Every-cycle compare of the short-bit DUT against the frame queue.
    always @(negedge clk) begin
        if (chk_en && !reset) begin
            checks++;
            if (rx_valid && frame_err) begin
                failures++;
                $display("FAIL both_pulses: rx_valid=1 frame_err=1 at cyc %0d, need at most one", cyc);
            end
            if (rx_valid || frame_err) begin
                pulse_cnt += rx_valid ? 1 : 0;
                err_cnt   += frame_err ? 1 : 0;
                if (rx_valid) pulse_log.push_back(data);
                last_cyc = cyc;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_pulse: valid=%0b err=%0b at cyc %0d, need none", rx_valid, frame_err, cyc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (frame_err !== e.err || cyc < e.due - 1 || cyc > e.due + 1) begin
                        failures++;
                        $display("FAIL pulse_kind_time: err=%0b cyc=%0d, need err=%0b cyc=%0d+-1", frame_err, cyc, e.err, e.due);
                    end
                    if (!e.err) model_data = e.b;
                end
            end else if (exp_q.size() > 0 && cyc > exp_q[0].due + 1) begin
                failures++;
                $display("FAIL missed_pulse: none by cyc %0d, need err=%0b byte %02h at %0d", cyc, exp_q[0].err, exp_q[0].b, exp_q[0].due);
                void'(exp_q.pop_front());
            end
            if (data !== model_data) begin
                failures++;
                $display("FAIL data_hold: got %02h, need %02h at cyc %0d", data, model_data, cyc);
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (rx_valid_l) begin
                l_cnt++;
                l_cyc = cyc;
            end
            if (frame_err_l) l_err++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, need %0h", name, act, exp);
        end
    endtask

    task automatic chk_rng(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            failures++;
            $display("FAIL %s: got %0d, need %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic hold(input logic v, input int n);
        rx = v;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic hold_l(input logic v, input int n);
        rx_l = v;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b, input logic stop_ok);
        exp_t e;
        e.err = !stop_ok;
        e.b   = b;
        e.due = cyc + 2 + H + 9 * C;
        exp_q.push_back(e);
        hold(1'b0, C);
        for (int i = 0; i < 8; i++) hold(b[i], C);
        hold(stop_ok, C);
    endtask

    initial begin
        int         fall;
        int         pc;
        int         ec;
        int         w;
        logic [7:0] b;
        checks     = 0;
        failures   = 0;
        cyc        = 0;
        chk_en     = 1'b0;
        model_data = 8'h00;
        pulse_cnt  = 0;
        err_cnt    = 0;
        l_cnt      = 0;
        l_err      = 0;
        rx         = 1'b1;
        rx_l       = 1'b1;
        reset      = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_data", 32'(data), 32'h00);
        chk("rst_valid", 32'(rx_valid), 32'h0);
        chk("rst_ferr", 32'(frame_err), 32'h0);
        chk("rst_busy", 32'(rx_busy), 32'h0);
        chk_en = 1'b1;
        hold(1'b1, 4);

        fall = cyc;
        send(8'h5A, 1'b1);
        hold(1'b1, C);
        chk("5a_count", 32'(pulse_cnt), 32'd1);
        chk("5a_data", 32'(pulse_log[$]), 32'h5A);
        chk_rng("5a_latency", last_cyc - fall, 153, 155);

        send(8'h01, 1'b1);
        send(8'h80, 1'b1);
        hold(1'b1, C);
        chk("b2b_count", 32'(pulse_cnt), 32'd3);
        chk("b2b_first", 32'(pulse_log[1]), 32'h01);
        chk("b2b_second", 32'(pulse_log[2]), 32'h80);

        pc = pulse_cnt;
        hold(1'b0, 5);
        hold(1'b1, 8);
        chk("glitch_busy", 32'(rx_busy), 32'h0);
        hold(1'b1, C);
        chk("glitch_count", 32'(pulse_cnt), 32'(pc));
        chk("glitch_ferr", 32'(err_cnt), 32'd0);

        send(8'hFF, 1'b0);
        hold(1'b0, 40 * C);
        hold(1'b1, C);
        chk("break_ferr", 32'(err_cnt), 32'd1);
        chk("break_valid", 32'(pulse_cnt), 32'(pc));
        chk("break_data", 32'(data), 32'h80);
        send(8'hC3, 1'b1);
        hold(1'b1, C);
        chk("c3_data", 32'(pulse_log[$]), 32'hC3);

        pc = pulse_cnt;
        ec = err_cnt;
        b  = 8'hAA;
        hold(1'b0, C);
        for (int i = 0; i < 4; i++) hold(b[i], C);
        hold(b[4], H);
        reset = 1'b1;
        rx    = 1'b1;
        exp_q.delete();
        model_data = 8'h00;
        hold(1'b1, 2);
        reset = 1'b0;
        chk("midrst_data", 32'(data), 32'h00);
        chk("midrst_busy", 32'(rx_busy), 32'h0);
        hold(1'b1, 2 * C);
        chk("midrst_nopulse", 32'(pulse_cnt + err_cnt), 32'(pc + ec));
        send(8'h3C, 1'b1);
        hold(1'b1, C);
        chk("3c_data", 32'(pulse_log[$]), 32'h3C);

        for (int n = 0; n < 40; n++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r == 0) begin
                hold(1'b0, int'($urandom_range(1, 5)));
                hold(1'b1, C + 4);
            end else if (r == 1) begin
                send(8'($urandom), 1'b0);
                hold(1'b0, int'($urandom_range(0, 3 * C)));
                hold(1'b1, C);
            end else begin
                send(8'($urandom), 1'b1);
                hold(1'b1, int'($urandom_range(0, 2 * C)));
            end
        end

        w = 0;
        while (exp_q.size() > 0 && w < 30 * C) begin
            hold(1'b1, 1);
            w++;
        end
        chk("drain", 32'(exp_q.size()), 32'd0);

        fall = cyc;
        b    = 8'hA5;
        hold_l(1'b0, CL);
        for (int i = 0; i < 8; i++) hold_l(b[i], CL);
        hold_l(1'b1, CL + 10);
        chk("long_count", 32'(l_cnt), 32'd1);
        chk_rng("long_latency", l_cyc - fall, 8247, 8249);
        chk("long_data", 32'(data_l), 32'hA5);
        chk("long_ferr", 32'(l_err), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
